// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave register block.
//   state_t      : decoder FSM states
//   CMD_RD_BIT   : command-byte bit that selects a read frame
//   BYTE_BITS    : bits per SPI byte
//   SYNC_STAGES  : depth of the input synchronizers
package spi_slave_pkg;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      CMD,
      WRITE,
      READ
   } state_t;

   localparam int unsigned CMD_RD_BIT  = 7;
   localparam int unsigned BYTE_BITS   = 8;
   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_regs_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with an extra history
// flop that turns level changes into single-cycle rise/fall pulses.
//   sys_clk, sys_rst_n : system clock, async active-low reset
//   pin                : asynchronous input
//   level              : synchronized level
//   rise, fall         : one-cycle pulses on synchronized transitions
// RST_VAL sets every flop at reset so an idle bus produces no edge.
module spi_sync_edge
   import spi_slave_pkg::*;
#(
   parameter logic RST_VAL = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-3, MSB-first slave in front of a byte-wide register bank.
// The SPI pins are oversampled on sys_clk; a command byte selects read or
// write and a start address, following bytes burst with auto-increment.
//   sys_clk, sys_rst_n : system clock, async active-low reset
//   spi_clk_i          : SPI clock (idles high)
//   spi_cs_i           : chip select, active low
//   spi_mosi_i         : master-out data
//   spi_miso_o         : slave-out data, driven low outside read data
//   regs_o             : flattened bank, reg k at [8k+7:8k]; reg 0 is ID
//   wr_strobe_o        : one-cycle pulse per committed write
//   wr_addr_o          : address of that write
//   frame_active_o     : high while a frame is being decoded
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_IDLE | after reset; ignore the bus until cs is seen high
// IDLE      | bus idle, waiting for cs to fall
// CMD       | shifting in the command byte
// WRITE     | shifting in data bytes, committing each to reg[addr]
// READ      | shifting reg[addr] out on MISO, byte by byte
module spi_slave_regs
   import spi_slave_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter logic [7:0]  ID    = 8'hA5
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     spi_clk_i,
   input  logic                     spi_cs_i,
   input  logic                     spi_mosi_i,
   output logic                     spi_miso_o,
   output logic [DEPTH*8-1:0]       regs_o,
   output logic                     wr_strobe_o,
   output logic [$clog2(DEPTH)-1:0] wr_addr_o,
   output logic                     frame_active_o
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned BCW = $clog2(BYTE_BITS);

   logic clk_level_unused, clk_rise, clk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic mosi_s;

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_clk (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pin       (spi_clk_i),
      .level     (clk_level_unused),
      .rise      (clk_rise),
      .fall      (clk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pin       (spi_cs_i),
      .level     (cs_s),
      .rise      (cs_rise),
      .fall      (cs_fall)
   );

   // MOSI needs only the level; same depth as clk so a detected rise sees
   // data sampled at the same instant.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mosi_q <= '0;
      end else begin
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
      end
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   state_t                 state;
   logic [BCW-1:0]         bit_cnt;
   logic [BYTE_BITS-2:0]   rx_sh;
   logic [BYTE_BITS-1:0]   tx_sh;
   logic [AW-1:0]          addr;
   logic [7:0]             regs_q [DEPTH];
   logic [1:0]             settle_cnt;

   logic [BYTE_BITS-1:0]   rx_byte;
   logic                   byte_done;
   logic [AW-1:0]          cmd_addr;
   logic [AW-1:0]          rd_addr;
   logic [7:0]             rd_data;

   assign rx_byte   = {rx_sh, mosi_s};
   assign byte_done = clk_rise && (bit_cnt == BCW'(BYTE_BITS-1));
   assign cmd_addr  = rx_byte[AW-1:0];

   // During CMD the reload address comes straight from the byte being
   // completed; afterwards it is the running burst address.
   always_comb begin
      rd_addr = (state == CMD) ? cmd_addr : addr;
      rd_data = (rd_addr == '0) ? ID : regs_q[rd_addr];
   end

   always_comb begin
      regs_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         regs_o[8*k +: 8] = (k == 0) ? ID : regs_q[k];
      end
   end

   // Synchronizers reset to an idle bus, so cs_s=1 just after reset says
   // nothing about the pin. settle_cnt holds WAIT_IDLE until the chain has
   // really sampled cs; a frame in flight at reset release is then ignored.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state          <= WAIT_IDLE;
         settle_cnt     <= 2'(SYNC_STAGES + 1);
         bit_cnt        <= '0;
         rx_sh          <= '0;
         tx_sh          <= '0;
         addr           <= '0;
         spi_miso_o     <= 1'b0;
         wr_strobe_o    <= 1'b0;
         wr_addr_o      <= '0;
         frame_active_o <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         wr_strobe_o <= 1'b0;
         if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
         end

         // cs release wins over a byte completing in the same cycle.
         if (state != WAIT_IDLE && cs_rise) begin
            state          <= IDLE;
            spi_miso_o     <= 1'b0;
            frame_active_o <= 1'b0;
         end else begin
            unique case (state)
               WAIT_IDLE: begin
                  if (settle_cnt == '0 && cs_s) begin
                     state <= IDLE;
                  end
               end
               IDLE: begin
                  if (cs_fall) begin
                     state          <= CMD;
                     bit_cnt        <= '0;
                     rx_sh          <= '0;
                     frame_active_o <= 1'b1;
                  end
               end
               CMD: begin
                  if (clk_rise) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     rx_sh   <= rx_byte[BYTE_BITS-2:0];
                     if (byte_done) begin
                        if (rx_byte[CMD_RD_BIT]) begin
                           tx_sh <= rd_data;
                           addr  <= cmd_addr + 1'b1;
                           state <= READ;
                        end else begin
                           addr  <= cmd_addr;
                           state <= WRITE;
                        end
                     end
                  end
               end
               WRITE: begin
                  if (clk_rise) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     rx_sh   <= rx_byte[BYTE_BITS-2:0];
                     if (byte_done) begin
                        if (addr != '0) begin
                           regs_q[addr] <= rx_byte;
                           wr_strobe_o  <= 1'b1;
                           wr_addr_o    <= addr;
                        end
                        addr <= addr + 1'b1;
                     end
                  end
               end
               READ: begin
                  if (clk_rise) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (byte_done) begin
                        tx_sh <= rd_data;
                        addr  <= addr + 1'b1;
                     end
                  end else if (clk_fall) begin
                     spi_miso_o <= tx_sh[BYTE_BITS-1];
                     tx_sh      <= {tx_sh[BYTE_BITS-2:0], 1'b0};
                  end
               end
               default: state <= WAIT_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_regs.sv
module tb_spi_slave_regs;

   localparam int DEPTH = 16;
   localparam logic [7:0] ID = 8'hA5;
   localparam int EV_WRITE = 0, EV_ACTIVE = 1, EV_MISO = 2;
   localparam int FK_NONE = 0, FK_CMD = 1, FK_WRITE = 2, FK_READ = 3;
   localparam int LAT = 3;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic spi_clk = 1'b1;
   logic spi_cs = 1'b1;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   logic [DEPTH*8-1:0] regs;
   logic wr_strobe;
   logic [3:0] wr_addr;
   logic frame_active;

   spi_slave_regs #(.DEPTH(DEPTH), .ID(ID)) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .spi_clk_i      (spi_clk),
      .spi_cs_i       (spi_cs),
      .spi_mosi_i     (spi_mosi),
      .spi_miso_o     (spi_miso),
      .regs_o         (regs),
      .wr_strobe_o    (wr_strobe),
      .wr_addr_o      (wr_addr),
      .frame_active_o (frame_active)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Transaction-level model: register contents, pending timed effects,
   // and expected read bytes.
   typedef struct {
      int         due;
      int         kind;
      int         addr;
      logic [7:0] data;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] m_regs [DEPTH];
   logic [7:0] exp_rd[$];
   int         strobe_log[$];
   int         fk = FK_NONE;
   int         m_addr = 0;
   bit         armed = 0;
   bit         check_en = 0;
   bit         exp_active = 0;
   bit         miso_free = 0;
   logic [7:0] tx_buf [8];
   logic [7:0] rx_buf [8];

   initial begin
      m_regs[0] = ID;
      for (int k = 1; k < DEPTH; k++) m_regs[k] = 8'h00;
   end

   always @(negedge sys_clk) begin : compare
      logic [DEPTH*8-1:0] exp_regs;
      bit exp_strobe;
      int exp_waddr;
      exp_strobe = 0;
      exp_waddr = 0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
         if (evq[i].due == cyc) begin
            case (evq[i].kind)
               EV_WRITE: begin
                  m_regs[evq[i].addr] = evq[i].data;
                  exp_strobe = 1;
                  exp_waddr = evq[i].addr;
               end
               EV_ACTIVE: exp_active = evq[i].data[0];
               default:   miso_free = evq[i].data[0];
            endcase
            evq.delete(i);
         end
      end
      if (check_en) begin
         for (int k = 0; k < DEPTH; k++) exp_regs[8*k +: 8] = m_regs[k];
         chk("regs", regs, exp_regs);
         chk("strobe", wr_strobe, exp_strobe);
         if (exp_strobe) chk("wr_addr", wr_addr, exp_waddr);
         chk("frame_active", frame_active, exp_active);
         if (!miso_free) chk("miso_idle", spi_miso, 1'b0);
      end
      if (wr_strobe) strobe_log.push_back(int'(wr_addr));
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (!armed || fk == FK_NONE) return;
      if (fk == FK_CMD) begin
         m_addr = int'(b[6:0]) % DEPTH;
         if (b[7]) begin
            fk = FK_READ;
            exp_rd.push_back(m_regs[m_addr]);
            m_addr = (m_addr + 1) % DEPTH;
            miso_free = 1;
         end else begin
            fk = FK_WRITE;
         end
      end else if (fk == FK_WRITE) begin
         if (m_addr != 0) evq.push_back('{cyc + LAT, EV_WRITE, m_addr, b});
         m_addr = (m_addr + 1) % DEPTH;
      end else begin
         exp_rd.push_back(m_regs[m_addr]);
         m_addr = (m_addr + 1) % DEPTH;
      end
   endtask

   task automatic cs_fall();
      wait_n(1);
      spi_cs = 1'b0;
      if (armed) begin
         fk = FK_CMD;
         evq.push_back('{cyc + LAT, EV_ACTIVE, 0, 8'h01});
      end
      wait_n(8);
   endtask

   task automatic cs_rise();
      wait_n(1);
      spi_cs = 1'b1;
      if (armed && fk != FK_NONE) begin
         evq.push_back('{cyc + LAT, EV_ACTIVE, 0, 8'h00});
         evq.push_back('{cyc + LAT, EV_MISO, 0, 8'h00});
      end
      fk = FK_NONE;
      exp_rd.delete();
      armed = 1;
      wait_n(16);
   endtask

   // Mode 3: drive MOSI on the falling edge, master samples MISO on the rise.
   task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] cap);
      cap = '0;
      for (int i = 0; i < nbits; i++) begin
         wait_n(1);
         spi_clk = 1'b0;
         spi_mosi = b[7-i];
         wait_n(8);
         spi_clk = 1'b1;
         cap = {cap[6:0], spi_miso};
         if (i == 7) model_byte(b);
         wait_n(7);
      end
   endtask

   task automatic frame(input logic [7:0] cmd, input int n);
      logic [7:0] dummy;
      cs_fall();
      xfer_bits(cmd, 8, dummy);
      for (int i = 0; i < n; i++) begin
         xfer_bits(cmd[7] ? 8'h00 : tx_buf[i], 8, rx_buf[i]);
         if (cmd[7]) begin
            if (exp_rd.size() > 0) chk("rd_model_byte", rx_buf[i], exp_rd.pop_front());
            else chk("rd_model_queue", exp_rd.size(), 1);
         end
      end
      cs_rise();
   endtask

   task automatic mid_reset();
      @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      evq.delete();
      exp_rd.delete();
      for (int k = 1; k < DEPTH; k++) m_regs[k] = 8'h00;
      exp_active = 0;
      miso_free = 0;
      fk = FK_NONE;
      armed = 0;
      repeat (3) @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] cap;
      repeat (4) @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b1;
      armed = 1;
      check_en = 1;
      wait_n(10);

      chk("rst_reg0", regs[7:0], 8'hA5);
      chk("rst_regs_hi", regs[127:8], 0);
      chk("rst_miso", spi_miso, 1'b0);
      chk("rst_strobe", wr_strobe, 1'b0);
      chk("rst_wr_addr", wr_addr, 4'd0);
      chk("rst_active", frame_active, 1'b0);

      // write burst
      strobe_log.delete();
      tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
      frame(8'h03, 3);
      chk("wb_reg3", regs[31:24], 8'h11);
      chk("wb_reg4", regs[39:32], 8'h22);
      chk("wb_reg5", regs[47:40], 8'h33);
      chk("wb_nstrobe", strobe_log.size(), 3);
      if (strobe_log.size() == 3) begin
         chk("wb_addr0", strobe_log[0], 3);
         chk("wb_addr1", strobe_log[1], 4);
         chk("wb_addr2", strobe_log[2], 5);
      end

      // read back
      frame(8'h83, 3);
      chk("rb_byte0", rx_buf[0], 8'h11);
      chk("rb_byte1", rx_buf[1], 8'h22);
      chk("rb_byte2", rx_buf[2], 8'h33);
      frame(8'h80, 1);
      chk("rb_id", rx_buf[0], 8'hA5);

      // wrap and protect
      strobe_log.delete();
      tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB; tx_buf[2] = 8'hCC;
      frame(8'h0F, 3);
      chk("wr_reg15", regs[127:120], 8'hAA);
      chk("wr_reg0", regs[7:0], 8'hA5);
      chk("wr_reg1", regs[15:8], 8'hCC);
      chk("wr_nstrobe", strobe_log.size(), 2);
      if (strobe_log.size() == 2) begin
         chk("wr_addr0", strobe_log[0], 15);
         chk("wr_addr1", strobe_log[1], 1);
      end

      // abort mid-byte
      strobe_log.delete();
      cs_fall();
      xfer_bits(8'h02, 8, cap);
      xfer_bits(8'h77, 5, cap);
      cs_rise();
      chk("ab_reg2", regs[23:16], 8'h00);
      chk("ab_nstrobe", strobe_log.size(), 0);
      chk("ab_fsm_idle", dut.state, spi_slave_pkg::IDLE);
      chk("ab_miso", spi_miso, 1'b0);
      chk("ab_active", frame_active, 1'b0);

      // reset in the middle of a write byte, cs held low afterwards
      strobe_log.delete();
      cs_fall();
      xfer_bits(8'h06, 8, cap);
      xfer_bits(8'h99, 4, cap);
      mid_reset();
      xfer_bits(8'hC3, 8, cap);
      wait_n(8);
      chk("mr_regs_hi", regs[127:8], 0);
      chk("mr_reg0", regs[7:0], 8'hA5);
      chk("mr_nstrobe", strobe_log.size(), 0);
      chk("mr_active", frame_active, 1'b0);
      chk("mr_miso", spi_miso, 1'b0);
      cs_rise();

      tx_buf[0] = 8'h5A;
      frame(8'h07, 1);
      chk("mr_reg7", regs[63:56], 8'h5A);
      chk("mr_post_nstrobe", strobe_log.size(), 1);
      if (strobe_log.size() == 1) chk("mr_post_addr", strobe_log[0], 7);
      frame(8'h87, 1);
      chk("mr_readback", rx_buf[0], 8'h5A);

      wait_n(10);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- RTL SPI slave that consumes the bus driven by the team's DPI SPI master: spi_clk, spi_mosi and spi_cs in, spi_miso out.
- Oversamples the SPI signals on sys_clk and decodes a command byte followed by burst data bytes.
- Services an internal byte-wide register bank that downstream logic reads through a flat port and monitors through a write strobe.
- Bus mode is fixed: mode 3 (CPOL=1, CPHA=1), MSB first.

Parameters:
- DEPTH, 16: number of 8-bit registers; power of two, 2..128.
- ID, 8'hA5: read-only value of register 0.

Ports:
- sys_clk  input  1  system clock; all logic is synchronous to it.
- sys_rst_n  input  1  asynchronous active-low reset.
- spi_clk_i  input  1  SPI clock from master; idles high; asynchronous to sys_clk.
- spi_cs_i  input  1  chip select, active low.
- spi_mosi_i  input  1  master-out data.
- spi_miso_o  output  1  slave-out data.
- regs_o  output  DEPTH*8  register bank, flattened; reg k occupies bits [8k+7:8k].
- wr_strobe_o  output  1  one-cycle pulse per committed register write.
- wr_addr_o  output  $clog2(DEPTH)  address of that write.
- frame_active_o  output  1  high while a frame is being decoded.

Behaviour:
- Clock/reset: one clock (sys_clk); reset is asynchronous, active-low (sys_rst_n).
- Reset values:
  - spi_miso_o=0, wr_strobe_o=0, wr_addr_o=0, frame_active_o=0.
  - Registers 1..DEPTH-1 = 0; register 0 always reads ID.
  - Synchronizers reset to the bus idle values: clk=1, cs=1, mosi=0.
- Input sampling:
  - spi_clk_i, spi_cs_i and spi_mosi_i each pass through a 2-flop synchronizer.
  - A third flop on clk and cs provides edge detection.
- Timing contract: SCLK high and low phases are each >= 4 sys_clk periods; CS setup/hold to SCLK edges >= 4 sys_clk.
- Reaction latency: 3 sys_clk from a pin change to the internal reaction.
- Mode 3 sampling: MOSI is sampled on the detected SCLK rising edge; MISO updates on the detected SCLK falling edge, 1 cycle after detection.
- FSM states: WAIT_IDLE, IDLE, CMD, WRITE, READ.
  - WAIT_IDLE: entered after reset. Moves to IDLE once synced cs=1, so a frame already in progress at reset release is ignored entirely.
  - IDLE -> CMD on cs falling edge. Bit counter and shift register are cleared; frame_active_o=1.
  - CMD: after 8 rising edges, the command byte is complete. cmd[7]=1 means read, 0 means write; addr = cmd[6:0] mod DEPTH.
    - Read: load the tx shift register with reg[addr], post-increment addr, go to READ.
    - Write: go to WRITE.
  - WRITE: each completed byte is written to reg[addr], then addr = (addr+1) mod DEPTH.
    - wr_strobe_o pulses for 1 cycle, in the cycle after the 8th rising edge, with wr_addr_o = the written address.
    - Writes to address 0 are dropped, with no strobe; addr still increments.
  - READ: MISO presents tx[7] on the first falling edge after the command byte, then shifts one bit per falling edge.
    - On the 8th rising edge of each byte, the next reg[addr] is reloaded and addr increments, wrapping mod DEPTH.
  - Any state other than WAIT_IDLE -> IDLE on cs rising edge.
    - A partial byte is discarded: no write, no strobe.
    - spi_miso_o=0 and frame_active_o=0, both 1 cycle after detection.
- MISO levels: spi_miso_o is 0 in IDLE, CMD and WRITE. It is never tri-stated.
- Simultaneous events:
  - A register write and a tx reload of the same address cannot coincide, because read and write frames are exclusive.
  - A cs rising edge in the same cycle as a byte completion takes priority: the byte is dropped.
- Asynchronous reset mid-frame: all state returns to its reset value at once; the block then waits in WAIT_IDLE.

Decomposition:
- Package spi_slave_pkg: FSM state enum; constants CMD_RD_BIT=7, BYTE_BITS=8, SYNC_STAGES=2.
- Sub-module spi_sync_edge (2-flop synchronizer plus rise/fall pulse outputs, reset value as a parameter). Instantiated for clk and cs; mosi uses its synchronizer only.
- Register bank and FSM stay in the top module.

Test Plan:
- Write burst: cmd 0x03, data 0x11 0x22 0x33, DEPTH=16.
  -> regs 3,4,5 = 11,22,33.
  -> Three wr_strobe_o pulses with wr_addr_o = 3, 4, 5.
  -> frame_active_o falls 1 cycle after cs rise is detected.
- Read back: cmd 0x83, clock 3 bytes.
  -> MISO bytes 0x11 0x22 0x33.
  -> cmd 0x80 with 1 byte returns 0xA5 (ID).
- Wrap and protect: cmd 0x0F, data 0xAA 0xBB 0xCC.
  -> reg15=AA; reg0 stays A5 with no strobe for address 0; reg1=CC.
- Abort: cmd 0x02, then only 5 data bits, then cs high.
  -> reg2 unchanged; no strobe; FSM in IDLE; MISO=0.
- Reset mid-frame: assert sys_rst_n low during a WRITE byte, then release with cs still low and clock 8 more bits.
  -> All outputs at reset values; no writes occur.
  -> The next full frame after cs goes high is decoded normally.
